// File: rtl/adder3_stream_join.sv
// Three-stream join adder: consumes one word from each input stream together,
// emits their unsigned sum through an output register backed by a one-entry skid.
module adder3_stream_join #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_s0,
  output logic            ready_s0,
  input  logic [DW-1:0]   data_s0,
  input  logic            valid_s1,
  output logic            ready_s1,
  input  logic [DW-1:0]   data_s1,
  input  logic            valid_s2,
  output logic            ready_s2,
  input  logic [DW-1:0]   data_s2,
  output logic            valid_m,
  input  logic            ready_m,
  output logic [DW+1:0]   data_m,
  output logic [CNT_W-1:0] sum_cnt
);

  logic             out_valid_q, out_valid_d;
  logic [DW+1:0]    out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DW+1:0]    skid_data_q, skid_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          all_v;
  logic          fire;
  logic          take;
  logic [DW+1:0] sum;

  assign all_v = valid_s0 & valid_s1 & valid_s2;
  // Ready depends only on the valids and the skid flag, never on ready_m.
  assign fire  = all_v & ~skid_valid_q & ~rst;
  assign take  = out_valid_q & ready_m;

  assign sum = {2'b00, data_s0} + {2'b00, data_s1} + {2'b00, data_s2};

  assign ready_s0 = fire;
  assign ready_s1 = fire;
  assign ready_s2 = fire;

  assign valid_m = out_valid_q;
  assign data_m  = out_data_q;
  assign sum_cnt = cnt_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    cnt_d        = cnt_q;
    if (fire && (!out_valid_q || ready_m)) begin
      out_data_d  = sum;
      out_valid_d = 1'b1;
    end else if (fire) begin
      skid_data_d  = sum;
      skid_valid_d = 1'b1;
    end else if (take) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (take) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
